// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller slice.
// Holds the FSM state encoding, direction codes driven on dir_o,
// default parameter values and a small elaboration-time helper.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int DEF_NUM_FLOORS  = 8;
    localparam int DEF_MOVE_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by floor stepping and door dwell.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_val this cycle (wins over counting)
//   load_val    - reload value
//   zero        - count has reached zero (counter holds at zero)
module lift_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lift_ctrl.sv
// Single-car lift controller using SCAN scheduling.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   car_req      - in-car floor buttons, one bit per floor
//   hall_req     - landing call buttons, one bit per floor
//   floor_o      - current car floor
//   dir_o        - 00 none, 01 up, 10 down
//   door_open_o  - door open indicator
//   busy_o       - controller not idle
//   pending_o    - registered outstanding-request mask
module lift_ctrl
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic [NUM_FLOORS-1:0] hall_req,
    output logic [FLOOR_W-1:0]    floor_o,
    output logic [1:0]            dir_o,
    output logic                  door_open_o,
    output logic                  busy_o,
    output logic [NUM_FLOORS-1:0] pending_o
);

    localparam int TMR_W = $clog2(max_int(MOVE_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [TMR_W-1:0]   MOVE_LD   = TMR_W'(MOVE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   DOOR_LD   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d, floor_up, floor_dn;
    logic [1:0]              dir_q, dir_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d, pend_or;
    logic                    any_above, any_below;
    logic                    tmr_load, tmr_zero;
    logic [TMR_W-1:0]        tmr_val;

    lift_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_q     <= DIR_NONE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
        end
    end

    // Decisions use this cycle's requests merged with the stored mask so a
    // request arriving on a step edge can still stop the car at the new floor.
    always_comb begin
        pend_or   = pending_q | car_req | hall_req;
        floor_up  = floor_q + FLOOR_W'(1);
        floor_dn  = floor_q - FLOOR_W'(1);
        any_above = 1'b0;
        any_below = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pend_or[i] && (FLOOR_W'(i) > floor_q)) any_above = 1'b1;
            if (pend_or[i] && (FLOOR_W'(i) < floor_q)) any_below = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        tmr_load = 1'b0;
        tmr_val  = MOVE_LD;

        case (state_q)
            IDLE: begin
                dir_d = DIR_NONE;
                if (pend_or[floor_q]) begin
                    state_d  = DOOR_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (any_above) begin
                    state_d  = MOVE_UP;
                    dir_d    = DIR_UP;
                    tmr_load = 1'b1;
                end else if (any_below) begin
                    state_d  = MOVE_DOWN;
                    dir_d    = DIR_DOWN;
                    tmr_load = 1'b1;
                end
            end

            MOVE_UP: begin
                if (tmr_zero) begin
                    if (floor_q == TOP_FLOOR) begin
                        state_d = IDLE;
                        dir_d   = DIR_NONE;
                    end else begin
                        floor_d  = floor_up;
                        tmr_load = 1'b1;
                        if (pend_or[floor_up]) begin
                            state_d = DOOR_OPEN;
                            tmr_val = DOOR_LD;
                        end
                    end
                end
            end

            MOVE_DOWN: begin
                if (tmr_zero) begin
                    if (floor_q == '0) begin
                        state_d = IDLE;
                        dir_d   = DIR_NONE;
                    end else begin
                        floor_d  = floor_dn;
                        tmr_load = 1'b1;
                        if (pend_or[floor_dn]) begin
                            state_d = DOOR_OPEN;
                            tmr_val = DOOR_LD;
                        end
                    end
                end
            end

            DOOR_OPEN: begin
                // pending[floor] is held clear here, so a set bit means a
                // fresh button press at this landing.
                if (pend_or[floor_q]) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (tmr_zero) begin
                    if ((dir_q != DIR_DOWN) && any_above) begin
                        state_d  = MOVE_UP;
                        dir_d    = DIR_UP;
                        tmr_load = 1'b1;
                    end else if (any_below) begin
                        state_d  = MOVE_DOWN;
                        dir_d    = DIR_DOWN;
                        tmr_load = 1'b1;
                    end else if (any_above) begin
                        state_d  = MOVE_UP;
                        dir_d    = DIR_UP;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        dir_d   = DIR_NONE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        pending_d = pend_or;
        if (state_d == DOOR_OPEN) pending_d[floor_d] = 1'b0;
    end

    always_comb begin
        case (state_q)
            MOVE_UP:   dir_o = DIR_UP;
            MOVE_DOWN: dir_o = DIR_DOWN;
            DOOR_OPEN: dir_o = dir_q;
            default:   dir_o = DIR_NONE;
        endcase
    end

    assign floor_o     = floor_q;
    assign door_open_o = (state_q == DOOR_OPEN);
    assign busy_o      = (state_q != IDLE);
    assign pending_o   = pending_q;

endmodule
